pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazard sources:
- load-use dependencies,
- taken branches resolved in ID,
- multi-cycle divides held in EX.

It also squashes the pipeline on a MEM-stage exception.

## Interface
Parameters:
- DIV_CYCLES, 32, number of cycles the pipeline front is frozen per divide (≥2)
- REGW, 5, register-index width

Ports:
- clk  in  1  pipeline clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- id_rs  in  REGW  source register A of instruction in ID
- id_rt  in  REGW  source register B of instruction in ID
- ex_rt  in  REGW  destination register of instruction in EX
- ex_memread  in  1  instruction in EX is a load
- id_branch_taken  in  1  branch in ID resolved taken this cycle
- ex_div_start  in  1  divide (div/divu) present in EX
- mem_exception  in  1  instruction in MEM raised an exception
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID
- stall_e  out  1  hold ID/EX
- flush_d  out  1  clear IF/ID
- flush_e  out  1  clear ID/EX
- flush_m  out  1  clear EX/MEM
- flush_w  out  1  clear MEM/WB
- div_done  out  1  one-cycle pulse: divider result may be captured
- div_abort  out  1  one-cycle pulse: in-flight divide cancelled
- exc_redirect  out  1  select exception vector for next PC

## Operation
- FSM states:
  - IDLE: reset state.
  - DIV_BUSY: holds a down-counter cnt, width clog2(DIV_CYCLES), reset 0.
- While resetn is low:
  - State is IDLE.
  - cnt is 0.
  - Every output is 0 regardless of inputs.
- Priority, highest first: exception > divide > load-use > branch.
- Exception (any state), when mem_exception=1:
  - flush_d, flush_e, flush_m, flush_w = 1 and exc_redirect = 1.
  - All stalls = 0.
  - If the state is DIV_BUSY: div_abort = 1 and the next state is IDLE with cnt = 0.
  - div_done = 0.
- Divide start (IDLE, ex_div_start=1, no exception):
  - stall_f, stall_d, stall_e = 1 and flush_m = 1, which inserts a bubble into MEM.
  - Next state is DIV_BUSY with cnt = DIV_CYCLES-1.
- DIV_BUSY with cnt≠0:
  - stall_f, stall_d, stall_e and flush_m = 1.
  - cnt decrements.
  - ex_div_start is ignored.
- DIV_BUSY with cnt=0:
  - div_done = 1 and all stalls and flushes = 0.
  - Next state is IDLE.
  - The divide advances to MEM on this edge.
  - ex_div_start, still high this cycle, must not restart a divide.
- Load-use (IDLE only, no exception, no divide start):
  - Condition: ex_memread=1, ex_rt≠0, and ex_rt equals id_rs or id_rt.
  - Outputs: stall_f = stall_d = 1 and flush_e = 1.
- Branch (IDLE only): id_branch_taken=1 with no load-use stall → flush_d = 1.
  - Under a load-use stall, id_branch_taken is ignored; the branch re-resolves next cycle.
- All outputs are combinational from state, cnt and inputs. No output is registered.

## Timing
- Load-use stall:
  - Exactly 1 cycle per hazard.
  - The dependent instruction leaves ID on the following edge.
- Divide:
  - Front end frozen for DIV_CYCLES consecutive cycles, counting the start cycle.
  - div_done is asserted in cycle DIV_CYCLES+1 after the start cycle.
- Exception:
  - Flushes and exc_redirect take effect in the same cycle.
  - The handler fetch occurs on the next edge.
- Reset mid-divide: cnt is cleared and the state is IDLE immediately (asynchronous). No div_done or div_abort pulse is issued.
- Back-to-back divides: a second ex_div_start is first honoured in the cycle after div_done.

## Structure
- Shared package pipe_pkg holds:
  - the state enum {IDLE, DIV_BUSY},
  - the REG_ZERO constant (0),
  - the default DIV_CYCLES localparam used by the divider.
- One natural sub-module, div_timer, containing the counter plus the load/decrement/zero flag.
- Hazard comparison and the output decode stay in pipeline_ctrl.

## Test plan
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 → one cycle with stall_f=stall_d=flush_e=1; next cycle all 0. Repeat with ex_rt=0 → no stall.
- Branch vs. stall: id_branch_taken=1 alone → flush_d=1. Same cycle as a load-use hazard → flush_d=0, stall_d=1.
- Divide with DIV_CYCLES=4: ex_div_start held high → stall_e=1 for 4 cycles, div_done=1 in cycle 5, stalls 0, no restart in cycle 6.
- Exception at cnt=2 in DIV_BUSY → div_abort=1, all four flushes=1, exc_redirect=1, state IDLE next cycle.
- Exception coincident with load-use and ex_div_start in IDLE → only the exception outputs are asserted; stalls 0, state stays IDLE.
- Reset mid-operation:
  - resetn low during DIV_BUSY at cnt=5 → all outputs 0 asynchronously.
  - After release, state is IDLE and no div_done pulse occurs.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_t          : sequencer state (IDLE, DIV_BUSY)
//   REG_ZERO         : index of the hard-wired zero register ($zero)
//   DEF_DIV_CYCLES   : default number of front-end freeze cycles per divide
//   cnt_width()      : width of the divide down-counter for a given cycle count
package pipe_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } state_t;

  localparam int REG_ZERO       = 0;
  localparam int DEF_DIV_CYCLES = 32;

  // Enough bits to hold DIV_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/div_timer.sv
// Down-counter that times a multi-cycle divide held in EX.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset (counter -> 0)
//   load        : load CYCLES-1 (start of a divide)
//   dec         : decrement by one
//   clear       : force to 0 (divide aborted)
//   cnt         : current count
//   zero        : cnt == 0
// clear has priority over load, load over dec.
module div_timer
  import pipe_pkg::*;
#(
  parameter int CYCLES = DEF_DIV_CYCLES,
  parameter int W      = cnt_width(CYCLES)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         dec,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         zero
);

  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the five-stage MIPS pipeline.
// Resolves load-use hazards, taken branches in ID and multi-cycle divides in
// EX, and squashes the pipeline on a MEM-stage exception.
// Priority, highest first: exception > divide > load-use > branch.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   id_rs, id_rt       : source registers of the instruction in ID
//   ex_rt              : destination register of the instruction in EX
//   ex_memread         : instruction in EX is a load
//   id_branch_taken    : branch in ID resolved taken
//   ex_div_start       : divide present in EX
//   mem_exception      : instruction in MEM raised an exception
//   stall_f/d/e        : hold PC, IF/ID, ID/EX
//   flush_d/e/m/w      : clear IF/ID, ID/EX, EX/MEM, MEM/WB
//   div_done           : one-cycle pulse, divider result may be captured
//   div_abort          : one-cycle pulse, in-flight divide cancelled
//   exc_redirect       : select exception vector for next PC
//   dbg_state, dbg_cnt : sequencer state and divide counter, for observation
// All control outputs are combinational; they are forced to 0 while resetn
// is low so reset takes effect without waiting for a clock.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int REGW       = 5,
  parameter int CW         = cnt_width(DIV_CYCLES)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] ex_rt,
  input  logic            ex_memread,
  input  logic            id_branch_taken,
  input  logic            ex_div_start,
  input  logic            mem_exception,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            flush_w,
  output logic            div_done,
  output logic            div_abort,
  output logic            exc_redirect,
  output state_t          dbg_state,
  output logic [CW-1:0]   dbg_cnt
);

  state_t        state_q, state_d;
  logic          t_load, t_dec, t_clear, t_zero;
  logic [CW-1:0] cnt;
  logic          load_use;

  div_timer #(.CYCLES(DIV_CYCLES), .W(CW)) u_div_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (t_load),
    .dec    (t_dec),
    .clear  (t_clear),
    .cnt    (cnt),
    .zero   (t_zero)
  );

  // A load into $zero never produces a real dependency.
  assign load_use = ex_memread && (ex_rt != REGW'(REG_ZERO)) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    t_load       = 1'b0;
    t_dec        = 1'b0;
    t_clear      = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_m      = 1'b0;
    flush_w      = 1'b0;
    div_done     = 1'b0;
    div_abort    = 1'b0;
    exc_redirect = 1'b0;

    if (mem_exception) begin
      flush_d      = 1'b1;
      flush_e      = 1'b1;
      flush_m      = 1'b1;
      flush_w      = 1'b1;
      exc_redirect = 1'b1;
      if (state_q == DIV_BUSY) begin
        div_abort = 1'b1;
        t_clear   = 1'b1;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_div_start) begin
            // Freeze the front and feed a bubble into MEM while EX divides.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            t_load  = 1'b1;
            state_d = DIV_BUSY;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (id_branch_taken) begin
            flush_d = 1'b1;
          end
        end
        DIV_BUSY: begin
          if (!t_zero) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            t_dec   = 1'b1;
          end else begin
            // Divide advances to MEM on this edge; a still-high
            // ex_div_start belongs to the finishing divide, not a new one.
            div_done = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (!resetn) begin
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      flush_m      = 1'b0;
      flush_w      = 1'b0;
      div_done     = 1'b0;
      div_abort    = 1'b0;
      exc_redirect = 1'b0;
    end
  end

  assign dbg_state = state_q;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with DIV_CYCLES=6, so both cnt=5 and cnt=2 occur.
// Output vector order: {stall_f, stall_d, stall_e, flush_d, flush_e,
//                       flush_m, flush_w, div_done, div_abort, exc_redirect}
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  localparam int DC   = 6;
  localparam int REGW = 5;
  localparam int CW   = 3;

  localparam logic [9:0] O_NONE   = 10'b0000000000;
  localparam logic [9:0] O_LDUSE  = 10'b1100100000;
  localparam logic [9:0] O_BRANCH = 10'b0001000000;
  localparam logic [9:0] O_DIV    = 10'b1110010000;
  localparam logic [9:0] O_DONE   = 10'b0000000100;
  localparam logic [9:0] O_EXC    = 10'b0001111001;
  localparam logic [9:0] O_EXCDIV = 10'b0001111011;

  logic            clk;
  logic            resetn;
  logic [REGW-1:0] id_rs, id_rt, ex_rt;
  logic            ex_memread, id_branch_taken, ex_div_start, mem_exception;
  logic            stall_f, stall_d, stall_e;
  logic            flush_d, flush_e, flush_m, flush_w;
  logic            div_done, div_abort, exc_redirect;
  state_t          dbg_state;
  logic [CW-1:0]   dbg_cnt;
  logic [9:0]      outs;

  int checks = 0;
  int passed = 0;

  pipeline_ctrl #(.DIV_CYCLES(DC), .REGW(REGW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .id_branch_taken (id_branch_taken),
    .ex_div_start    (ex_div_start),
    .mem_exception   (mem_exception),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .stall_e         (stall_e),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .flush_m         (flush_m),
    .flush_w         (flush_w),
    .div_done        (div_done),
    .div_abort       (div_abort),
    .exc_redirect    (exc_redirect),
    .dbg_state       (dbg_state),
    .dbg_cnt         (dbg_cnt)
  );

  assign outs = {stall_f, stall_d, stall_e, flush_d, flush_e,
                 flush_m, flush_w, div_done, div_abort, exc_redirect};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [REGW-1:0] rs, rt, xrt;
    logic            memread, br, div, exc;
    logic [9:0]      exp;
  } vec_t;

  vec_t vecs[11];

  // Driver tasks
  task automatic drive(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                       input logic [REGW-1:0] xrt, input logic memread,
                       input logic br, input logic div, input logic exc);
    id_rs = rs; id_rt = rt; ex_rt = xrt;
    ex_memread = memread; id_branch_taken = br;
    ex_div_start = div; mem_exception = exc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic chk_outs(input string name, input logic [9:0] exp);
    checks++;
    if (outs === exp) passed++;
    else $display("FAIL %s outs got %b want %b", name, outs, exp);
  endtask

  task automatic chk_state(input string name, input state_t exp_s,
                           input logic [CW-1:0] exp_c);
    checks++;
    if (dbg_state === exp_s && dbg_cnt === exp_c) passed++;
    else $display("FAIL %s state/cnt got %0d/%0d want %0d/%0d",
                  name, dbg_state, dbg_cnt, exp_s, exp_c);
  endtask

  initial begin
    vecs[0]  = '{"idle_zero",      5'd0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[1]  = '{"lduse_rs",       5'd8, 5'd3,  5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LDUSE};
    vecs[2]  = '{"lduse_rt",       5'd2, 5'd8,  5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_LDUSE};
    vecs[3]  = '{"lduse_r0",       5'd0, 5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[4]  = '{"lduse_nomatch",  5'd9, 5'd10, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[5]  = '{"match_noload",   5'd8, 5'd8,  5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[6]  = '{"branch",         5'd1, 5'd2,  5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[7]  = '{"branch_lduse",   5'd8, 5'd1,  5'd8, 1'b1, 1'b1, 1'b0, 1'b0, O_LDUSE};
    vecs[8]  = '{"branch_r0load",  5'd0, 5'd4,  5'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[9]  = '{"exc_all",        5'd8, 5'd8,  5'd8, 1'b1, 1'b1, 1'b1, 1'b1, O_EXC};
    vecs[10] = '{"exc_alone",      5'd0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_EXC};

    // Reset: outputs must be 0 even with every input asserted.
    resetn = 1'b0;
    drive(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk_outs("reset_outs", O_NONE);
    chk_state("reset_state", IDLE, 3'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();

    // Table-driven IDLE vectors; state must remain IDLE after each edge.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].xrt, vecs[i].memread,
            vecs[i].br, vecs[i].div, vecs[i].exc);
      #1;
      chk_outs(vecs[i].name, vecs[i].exp);
      tick();
      chk_state({vecs[i].name, "_next"}, IDLE, 3'd0);
    end

    // Load-use lasts one cycle: next cycle the dependent has left ID.
    drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk_outs("ldseq_c1", O_LDUSE);
    tick();
    drive(5'd8, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_outs("ldseq_c2", O_NONE);
    tick();

    // Divide with ex_div_start held: DC frozen cycles, done in DC+1.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk_outs("div_c1", O_DIV);
    tick();
    for (int k = 2; k <= DC; k++) begin
      chk_state($sformatf("div_c%0d_st", k), DIV_BUSY, CW'(DC + 1 - k));
      chk_outs($sformatf("div_c%0d", k), O_DIV);
      tick();
    end
    chk_state("div_done_st", DIV_BUSY, 3'd0);
    chk_outs("div_done", O_DONE);
    tick();
    ex_div_start = 1'b0;
    #1;
    chk_state("div_after_st", IDLE, 3'd0);
    chk_outs("div_after", O_NONE);
    tick();

    // Back-to-back: start held through done is honoured the cycle after.
    ex_div_start = 1'b1;
    for (int k = 1; k <= DC; k++) tick();
    chk_outs("b2b_done", O_DONE);
    tick();
    chk_state("b2b_restart_st", IDLE, 3'd0);
    chk_outs("b2b_restart", O_DIV);
    tick();
    ex_div_start = 1'b0;
    chk_state("b2b_busy", DIV_BUSY, 3'd5);

    // Exception at cnt=2 aborts the divide.
    tick(); tick(); tick();
    chk_state("exc_cnt2_st", DIV_BUSY, 3'd2);
    mem_exception = 1'b1;
    #1 chk_outs("exc_abort", O_EXCDIV);
    tick();
    mem_exception = 1'b0;
    #1;
    chk_state("exc_abort_next", IDLE, 3'd0);
    chk_outs("exc_abort_quiet", O_NONE);
    tick();

    // Reset mid-divide at cnt=5: immediate clear, no later pulses.
    ex_div_start = 1'b1;
    tick();
    chk_state("rst_cnt5", DIV_BUSY, 3'd5);
    #2;
    resetn = 1'b0;
    mem_exception = 1'b1;
    #1;
    chk_outs("rst_async_outs", O_NONE);
    chk_state("rst_async_state", IDLE, 3'd0);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int k = 0; k < DC + 2; k++) begin
      tick();
      chk_outs($sformatf("rst_quiet_%0d", k), O_NONE);
    end
    chk_state("rst_final", IDLE, 3'd0);

    // Final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
